// File: rtl/nod_shift_mult.sv
// nod_shift_mult: approximate multiplier back end.
// Takes the NOD one-hot code of operand A (nearest power of two) and the
// exact operand B, and produces B * 2^k, where k is the index of the set bit.
// The datapath is a two-stage valid/ready pipeline: encode, then shift.
// Malformed (non-one-hot) codes are flagged per beat and counted in a
// saturating counter.

module nod_shift_mult #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH:0]     a_nod_i,
    input  logic               a_zero_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic               zero_o,
    output logic               err_o,
    output logic [CNT_W-1:0]   err_cnt_o
);

    localparam int K_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] NOD_ONE = {{WIDTH{1'b0}}, 1'b1};

    logic               s1_v;
    logic [K_W-1:0]     s1_k;
    logic [WIDTH-1:0]   s1_b;
    logic               s1_zero;
    logic               s1_err;

    logic               s1_adv;
    logic               s2_adv;
    logic               accept;

    logic [K_W-1:0]     in_k;
    logic               in_multi;
    logic               in_err;
    logic               in_zero;
    logic [2*WIDTH-1:0] shifted;

    // Each stage moves when its successor is empty or moving; the input side
    // therefore sees downstream back-pressure in the same cycle.
    assign s2_adv  = !valid_o || ready_i;
    assign s1_adv  = !s1_v || s2_adv;
    assign ready_o = s1_adv;
    assign accept  = valid_i && s1_adv;

    // A code with more than one bit set still leaves bits after clearing the
    // lowest one; an all-zero code is malformed unless the zero flag explains it.
    assign in_multi = (a_nod_i & (a_nod_i - NOD_ONE)) != '0;
    assign in_err   = !a_zero_i && ((a_nod_i == '0) || in_multi);
    assign in_zero  = a_zero_i || (b_i == '0) || in_err;

    // Index of the set bit; for malformed codes the value is unused because
    // the beat is forced to a zero product.
    always_comb begin
        in_k = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            if (a_nod_i[i]) begin
                in_k = K_W'(i);
            end
        end
    end

    assign shifted = {{WIDTH{1'b0}}, s1_b} << s1_k;

    // Stage 1: capture the encoded shift amount, B and the beat flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v    <= 1'b0;
            s1_k    <= '0;
            s1_b    <= '0;
            s1_zero <= 1'b0;
            s1_err  <= 1'b0;
        end else if (s1_adv) begin
            s1_v <= valid_i;
            if (valid_i) begin
                s1_k    <= in_k;
                s1_b    <= b_i;
                s1_zero <= in_zero;
                s1_err  <= in_err;
            end
        end
    end

    // Stage 2: perform the shift and hold the result until it is consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            prod_o  <= '0;
            zero_o  <= 1'b0;
            err_o   <= 1'b0;
        end else if (s2_adv) begin
            valid_o <= s1_v;
            if (s1_v) begin
                prod_o <= s1_zero ? '0 : shifted;
                zero_o <= s1_zero;
                err_o  <= s1_err;
            end
        end
    end

    // Count malformed beats as they are accepted, sticking at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_o <= '0;
        end else if (accept && in_err && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_nod_shift_mult.sv
// tb_nod_shift_mult: directed bench for nod_shift_mult.
// A vector table streamed back-to-back, plus hand-written sequences for the
// error-counter saturation, output stall and mid-flight reset cases.

module tb_nod_shift_mult;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int NV    = 10;

    logic               clk_i;
    logic               rst_ni;
    logic               valid_i;
    logic               ready_o;
    logic [WIDTH:0]     a_nod_i;
    logic               a_zero_i;
    logic [WIDTH-1:0]   b_i;
    logic               valid_o;
    logic               ready_i;
    logic [2*WIDTH-1:0] prod_o;
    logic               zero_o;
    logic               err_o;
    logic [CNT_W-1:0]   err_cnt_o;

    typedef struct {
        logic [WIDTH:0]     nod;
        logic               zf_in;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] prod;
        logic               zf;
        logic               err;
    } vec_t;

    vec_t vecs [NV];

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int exp_cnt  = 0;

    nod_shift_mult #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .a_nod_i   (a_nod_i),
        .a_zero_i  (a_zero_i),
        .b_i       (b_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .prod_o    (prod_o),
        .zero_o    (zero_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [WIDTH:0] nod, input logic zf_in,
                                  input logic [WIDTH-1:0] b);
        valid_i  = 1'b1;
        a_nod_i  = nod;
        a_zero_i = zf_in;
        b_i      = b;
    endtask

    task automatic do_reset();
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_ni  = 1'b1;
        exp_cnt = 0;
    endtask

    logic [2*WIDTH-1:0] exp_q [$];
    logic [WIDTH:0]     st_nod  [4];
    logic [WIDTH-1:0]   st_b    [4];
    logic [2*WIDTH-1:0] st_prod [4];

    initial begin
        vecs[0] = '{9'h100, 1'b0, 8'hAA, 16'hAA00, 1'b0, 1'b0};
        vecs[1] = '{9'h040, 1'b0, 8'h03, 16'h00C0, 1'b0, 1'b0};
        vecs[2] = '{9'h001, 1'b0, 8'hFF, 16'h00FF, 1'b0, 1'b0};
        vecs[3] = '{9'h100, 1'b1, 8'h55, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{9'h010, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0};
        vecs[5] = '{9'h003, 1'b0, 8'h12, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{9'h000, 1'b0, 8'h34, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{9'h080, 1'b0, 8'hFF, 16'h7F80, 1'b0, 1'b0};
        vecs[8] = '{9'h002, 1'b0, 8'h81, 16'h0102, 1'b0, 1'b0};
        vecs[9] = '{9'h000, 1'b1, 8'h00, 16'h0000, 1'b1, 1'b0};

        st_nod[0] = 9'h001; st_b[0] = 8'h11; st_prod[0] = 16'h0011;
        st_nod[1] = 9'h004; st_b[1] = 8'h22; st_prod[1] = 16'h0088;
        st_nod[2] = 9'h010; st_b[2] = 8'h33; st_prod[2] = 16'h0330;
        st_nod[3] = 9'h040; st_b[3] = 8'h44; st_prod[3] = 16'h1100;

        a_nod_i  = '0;
        a_zero_i = 1'b0;
        b_i      = '0;

        // ---- reset state ----
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        #1;
        check_output("rst_valid_o", 32'(valid_o), 32'd0);
        check_output("rst_prod_o", 32'(prod_o), 32'd0);
        check_output("rst_zero_o", 32'(zero_o), 32'd0);
        check_output("rst_err_o", 32'(err_o), 32'd0);
        check_output("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check_output("rst_ready_o", 32'(ready_o), 32'd1);

        // ---- table streamed back-to-back, ready_i held high ----
        for (int i = 0; i < NV + 2; i++) begin
            @(negedge clk_i);
            if (i >= 2) begin
                check_output($sformatf("tbl%0d_valid", i - 2), 32'(valid_o), 32'd1);
                check_output($sformatf("tbl%0d_prod", i - 2), 32'(prod_o), 32'(vecs[i-2].prod));
                check_output($sformatf("tbl%0d_zero", i - 2), 32'(zero_o), 32'(vecs[i-2].zf));
                check_output($sformatf("tbl%0d_err", i - 2), 32'(err_o), 32'(vecs[i-2].err));
            end
            check_output($sformatf("tbl%0d_err_cnt", i), 32'(err_cnt_o), 32'(exp_cnt));
            if (i < NV) begin
                apply_stimulus(vecs[i].nod, vecs[i].zf_in, vecs[i].b);
                if (vecs[i].err) exp_cnt++;
            end else begin
                valid_i = 1'b0;
            end
        end
        @(negedge clk_i);
        check_output("tbl_drained_valid", 32'(valid_o), 32'd0);

        // ---- error counter saturation: 300 malformed beats ----
        do_reset();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (i == 254) check_output("sat_cnt_254", 32'(err_cnt_o), 32'hFE);
            if (i == 255) check_output("sat_cnt_255", 32'(err_cnt_o), 32'hFF);
            apply_stimulus(9'h003, 1'b0, 8'h5A);
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        check_output("sat_cnt_300", 32'(err_cnt_o), 32'hFF);

        // ---- output stall: 4 beats, ready_i low for the first 5 cycles ----
        do_reset();
        begin
            int idx;
            int got;
            idx = 0;
            got = 0;
            exp_q.delete();
            for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                @(negedge clk_i);
                ready_i = (cyc >= 5);
                if (idx < 4) apply_stimulus(st_nod[idx], 1'b0, st_b[idx]);
                else valid_i = 1'b0;
                #1;
                if (cyc < 2) check_output($sformatf("stall_ready_c%0d", cyc), 32'(ready_o), 32'd1);
                if (cyc >= 2 && cyc < 5) begin
                    check_output($sformatf("stall_ready_c%0d", cyc), 32'(ready_o), 32'd0);
                    check_output($sformatf("stall_valid_c%0d", cyc), 32'(valid_o), 32'd1);
                    check_output($sformatf("stall_prod_c%0d", cyc), 32'(prod_o), 32'(st_prod[0]));
                end
                if (valid_i && ready_o) begin
                    exp_q.push_back(st_prod[idx]);
                    idx++;
                end
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) begin
                        check_output("stall_unexpected_beat", 32'(prod_o), 32'hDEAD);
                    end else begin
                        check_output($sformatf("stall_out%0d", got), 32'(prod_o), 32'(exp_q.pop_front()));
                    end
                    got++;
                end
            end
            check_output("stall_beats_out", 32'(got), 32'd4);
            @(negedge clk_i);
            valid_i = 1'b0;
            #1;
            check_output("stall_drained", 32'(valid_o), 32'd0);
        end

        // ---- reset with two beats in flight ----
        do_reset();
        ready_i = 1'b0;
        @(negedge clk_i);
        apply_stimulus(9'h003, 1'b0, 8'h12);
        @(negedge clk_i);
        apply_stimulus(9'h100, 1'b0, 8'hAA);
        @(negedge clk_i);
        valid_i = 1'b0;
        #1;
        check_output("midrst_pre_cnt", 32'(err_cnt_o), 32'd1);
        check_output("midrst_pre_valid", 32'(valid_o), 32'd1);
        check_output("midrst_pre_ready", 32'(ready_o), 32'd0);
        rst_ni = 1'b0;
        #1;
        check_output("midrst_valid_o", 32'(valid_o), 32'd0);
        check_output("midrst_err_cnt", 32'(err_cnt_o), 32'd0);
        check_output("midrst_prod_o", 32'(prod_o), 32'd0);
        @(negedge clk_i);
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check_output($sformatf("midrst_no_stale%0d", i), 32'(valid_o), 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
